// File: rtl/am_regfile_writeback.sv
// Write-back end of the addressing-mode path: write FIFO feeding an 8x16 register file with two read ports and an R0 tap.
// Optional macro REGFILE_BYPASS_EN: reads forward the youngest matching queued write ahead of the array.
module am_regfile_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wb_hold,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] acc_data,
  output logic              pending,
  output logic              addr_err
);
  localparam int NREG = 1 << ADDR_W;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] LAST_C  = PW'(QDEPTH - 1);

  logic [DATA_W-1:0] regs_r   [NREG];
  logic [ADDR_W-1:0] q_addr_r [QDEPTH];
  logic [DATA_W-1:0] q_data_r [QDEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic              addr_err_r;
  logic              legal_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Array value, optionally overridden by the youngest queued write to the same index
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = regs_r[idx];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < QDEPTH; i++) begin
      int slot;
      slot = int'(head_r) + i;
      if (slot >= QDEPTH) begin
        slot = slot - QDEPTH;
      end else begin
        slot = slot;
      end
      if ((i < int'(count_r)) && (q_addr_r[slot] == idx)) begin
        val = q_data_r[slot];
      end else begin
        val = val;
      end
    end
`endif
    return val;
  endfunction

  assign legal_s  = ((wr_addr >> ADDR_W) == 16'd0);
  assign wr_ready = (count_r < DEPTH_C);
  assign accept_s = wr_valid && wr_ready;
  assign push_s   = accept_s && legal_s;
  assign pop_s    = (count_r != {CW{1'b0}}) && !wb_hold;
  assign pending  = (count_r != {CW{1'b0}});
  assign addr_err = addr_err_r;

  // Queue pointers, occupancy and sticky illegal-address flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      addr_err_r <= 1'b0;
    end else begin
      if (push_s) tail_r <= ptr_inc(tail_r);
      if (pop_s)  head_r <= ptr_inc(head_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
      if (accept_s && !legal_s) addr_err_r <= 1'b1;
    end
  end

  // Queue entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr_r[i] <= {ADDR_W{1'b0}};
        q_data_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      q_addr_r[tail_r] <= wr_addr[ADDR_W-1:0];
      q_data_r[tail_r] <= wr_data;
    end
  end

  // Register array, written by the queue head on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (pop_s) begin
      regs_r[q_addr_r[head_r]] <= q_data_r[head_r];
    end
  end

  assign rd1_data = read_port(rd1_addr);
  assign rd2_data = read_port(rd2_addr);
  assign acc_data = read_port({ADDR_W{1'b0}});
endmodule

// File: tb/tb_am_regfile_writeback.sv
// Directed self-checking bench for am_regfile_writeback; expectations follow REGFILE_BYPASS_EN when defined.
module tb_am_regfile_writeback;
  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wb_hold;
  logic [2:0]  rd1_addr;
  logic [15:0] rd1_data;
  logic [2:0]  rd2_addr;
  logic [15:0] rd2_data;
  logic [15:0] acc_data;
  logic        pending;
  logic        addr_err;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  am_regfile_writeback dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wb_hold(wb_hold),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd2_addr(rd2_addr), .rd2_data(rd2_data),
    .acc_data(acc_data), .pending(pending), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;
    wb_hold = 1'b0; rd1_addr = 3'd0; rd2_addr = 3'd0;
    step(); step();
    chk("reset_ready", 32'(wr_ready), 32'h1);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_addr_err", 32'(addr_err), 32'h0);
    chk("reset_acc", 32'(acc_data), 32'h0);
    rst_n = 1'b1;
    step();

    // MVI R3 <- BEEF
    wr_valid = 1'b1; wr_addr = 16'h0003; wr_data = 16'hBEEF; rd1_addr = 3'd3;
    step();
    wr_valid = 1'b0;
    chk("mvi_pending", 32'(pending), 32'h1);
    chk("mvi_pre_read", 32'(rd1_data), BYP ? 32'hBEEF : 32'h0);
    step();
    chk("mvi_pending_clr", 32'(pending), 32'h0);
    chk("mvi_read", 32'(rd1_data), 32'hBEEF);

    // LDA R0 <- 1234
    wr_valid = 1'b1; wr_addr = 16'h0000; wr_data = 16'h1234;
    step();
    wr_valid = 1'b0;
    step();
    chk("lda_acc", 32'(acc_data), 32'h1234);

    // Hold: two writes to R1 fill the queue
    wb_hold = 1'b1; rd1_addr = 3'd1;
    wr_valid = 1'b1; wr_addr = 16'h0001; wr_data = 16'hAAAA;
    step();
    chk("hold_ready_1", 32'(wr_ready), 32'h1);
    wr_data = 16'hBBBB;
    step();
    wr_valid = 1'b0;
    chk("hold_ready_full", 32'(wr_ready), 32'h0);
    chk("hold_read_r1", 32'(rd1_data), BYP ? 32'hBBBB : 32'h0);
    step();
    chk("hold_still_full", 32'(wr_ready), 32'h0);
    wb_hold = 1'b0;
    step();
    chk("hold_commit1_ready", 32'(wr_ready), 32'h1);
    chk("hold_commit1_r1", 32'(rd1_data), BYP ? 32'hBBBB : 32'hAAAA);
    step();
    chk("hold_commit2_r1", 32'(rd1_data), 32'hBBBB);
    chk("hold_commit2_pending", 32'(pending), 32'h0);

    // Back-to-back: push+pop in the same cycle keeps one entry queued
    wr_valid = 1'b1; wr_addr = 16'h0002; wr_data = 16'h1111; rd1_addr = 3'd2; rd2_addr = 3'd4;
    step();
    wr_addr = 16'h0004; wr_data = 16'h2222;
    step();
    wr_valid = 1'b0;
    chk("b2b_pending", 32'(pending), 32'h1);
    chk("b2b_r2", 32'(rd1_data), 32'h1111);
    chk("b2b_r4_pre", 32'(rd2_data), BYP ? 32'h2222 : 32'h0);
    step();
    chk("b2b_r4", 32'(rd2_data), 32'h2222);

    // Illegal address: dropped, sticky error, R0 untouched
    wr_valid = 1'b1; wr_addr = 16'h0108; wr_data = 16'h5555; rd1_addr = 3'd0;
    #1;
    chk("illegal_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    chk("illegal_err", 32'(addr_err), 32'h1);
    chk("illegal_pending", 32'(pending), 32'h0);
    step(); step();
    chk("illegal_sticky", 32'(addr_err), 32'h1);
    chk("illegal_r0", 32'(rd1_data), 32'h1234);
    chk("illegal_acc", 32'(acc_data), 32'h1234);

    // Held R5 write: bypass visibility
    wb_hold = 1'b1; rd2_addr = 3'd5;
    wr_valid = 1'b1; wr_addr = 16'h0005; wr_data = 16'h7777;
    step();
    chk("bypass_r5", 32'(rd2_data), BYP ? 32'h7777 : 32'h0);
    wr_addr = 16'h0006; wr_data = 16'h9999;
    step();
    wr_valid = 1'b0;
    chk("prereset_full", 32'(wr_ready), 32'h0);

    // Reset with two entries queued: they must never commit
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_pending", 32'(pending), 32'h0);
    step();
    rst_n = 1'b1; wb_hold = 1'b0; rd1_addr = 3'd6;
    step(); step();
    chk("post_reset_ready", 32'(wr_ready), 32'h1);
    chk("post_reset_pending", 32'(pending), 32'h0);
    chk("post_reset_err", 32'(addr_err), 32'h0);
    chk("post_reset_r5", 32'(rd2_data), 32'h0);
    chk("post_reset_r6", 32'(rd1_data), 32'h0);
    chk("post_reset_acc", 32'(acc_data), 32'h0);
    rd1_addr = 3'd3;
    #1;
    chk("post_reset_r3", 32'(rd1_data), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
